// File: rtl/mux_reg_nx1.sv
// N-input registered mux with valid/ready on both sides; direct-select or round-robin grant.
// Define MUX_REG_STALL_CNT_EN to add a saturating stall counter output (stall_cnt_o).
module mux_reg_nx1 #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [NUM_IN-1:0]       in_valid_i,
    output logic [NUM_IN-1:0]       in_ready_o,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    mode_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_sel_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
`ifdef MUX_REG_STALL_CNT_EN
    ,output logic [15:0]            stall_cnt_o
`endif
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                grant_vld;
    logic [SEL_W-1:0]    grant;
    logic [2*NUM_IN-1:0] rot_valid;
    logic [WIDTH-1:0]    grant_data;
    logic                can_load;
    logic                xfer;

    assign can_load  = !out_valid_q || out_ready_i;
    // Doubling the valid vector lets the scan from rr_ptr wrap without modulo indexing.
    assign rot_valid = {in_valid_i, in_valid_i} >> rr_ptr_q;

    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        if (!mode_i) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (int'(sel_i) == i && in_valid_i[i]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (!grant_vld && rot_valid[k]) begin
                    grant_vld = 1'b1;
                    idx       = int'(rr_ptr_q) + k;
                    if (idx >= NUM_IN) idx = idx - NUM_IN;
                    grant     = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(grant) == i) grant_data = in_data_i[i*WIDTH +: WIDTH];
        end
    end

    assign xfer = grant_vld && can_load && !reset_i;

    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready_o[i] = xfer && (int'(grant) == i);
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_sel_d   = grant;
            out_valid_d = 1'b1;
            if (mode_i) begin
                rr_ptr_d = (int'(grant) == NUM_IN - 1) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;
    assign out_valid_o = out_valid_q;

`ifdef MUX_REG_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // Base build: handshake only, no stall counter.
`endif

endmodule
